lcd_write_scheduler: RTL and testbench

Shares the HD44780 LCD bus between two byte-write requesters, for example the init/refresh sequencer and a cursor/status updater. It arbitrates round-robin and latches the granted byte and its RS bit. It then generates one complete write cycle: address setup, E pulse, hold, and the controller execution wait. The block owns lcd_e/lcd_rs/lcd_rw/lcd_db and is the only driver of the LCD pins.

---
 rtl/lcd_write_scheduler.sv | 163 ++++++++++++++++
 tb/tb_lcd_write_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_scheduler.sv
// rtl/lcd_write_scheduler.sv - round-robin two-port HD44780 write cycle generator
module lcd_write_scheduler #(
  parameter int T_SETUP     = 2,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } state_t;

  // Counter reload values: a phase of T cycles counts T-1 down to 0.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             e_n, rs_n, ack0_n, ack1_n, busy_n;
  logic [7:0]       db_n;
  logic             last_grant, last_n;
  logic             pick0, pick1;
  logic             exec_long;
  logic             cnt_zero;

  // The bus never reads the controller, so RW is permanently write.
  assign lcd_rw = 1'b0;

  // Round-robin pick: a lone requester always wins, a tie goes to the port not served last.
  assign pick0 = req0 & (~req1 | last_grant);
  assign pick1 = req1 & (~req0 | ~last_grant);

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign exec_long = ~lcd_rs & (lcd_db[7:2] == 6'd0) & (lcd_db[1:0] != 2'd0);

  assign cnt_zero = (cnt == '0);

  // Next-state and next-output logic for the write-cycle sequencer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    e_n     = lcd_e;
    rs_n    = lcd_rs;
    db_n    = lcd_db;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    busy_n  = busy;
    last_n  = last_grant;
    unique case (state)
      IDLE: begin
        if (pick0) begin
          rs_n    = rs0;
          db_n    = data0;
          ack0_n  = 1'b1;
          last_n  = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = LD_SETUP;
          state_n = SETUP;
        end else if (pick1) begin
          rs_n    = rs1;
          db_n    = data1;
          ack1_n  = 1'b1;
          last_n  = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = LD_SETUP;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          e_n     = 1'b1;
          cnt_n   = LD_PW;
          state_n = PULSE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          e_n     = 1'b0;
          cnt_n   = LD_HOLD;
          state_n = HOLD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          cnt_n   = exec_long ? LD_LONG : LD_EXEC;
          state_n = EXEC;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: begin
        e_n     = 1'b0;
        busy_n  = 1'b0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any cycle and drops E at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_db     <= 8'h00;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lcd_e      <= e_n;
      lcd_rs     <= rs_n;
      lcd_db     <= db_n;
      ack0       <= ack0_n;
      ack1       <= ack1_n;
      busy       <= busy_n;
      last_grant <= last_n;
    end
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// tb/tb_lcd_write_scheduler.sv - randomized bench with timeline reference model
module tb_lcd_write_scheduler;

  localparam int TS   = 2;
  localparam int TPW  = 5;
  localparam int TH   = 3;
  localparam int TX   = 20;
  localparam int TXL  = 150;
  localparam int TOT  = TS + TPW + TH + TX;
  localparam int TOTL = TS + TPW + TH + TXL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  lcd_write_scheduler #(
    .T_SETUP(TS), .T_PW(TPW), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL), .CNT_W(17)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: each accepted write is a timeline anchored at its accept edge.
  int         edge_n = 0;
  int         t0 = 0;
  int         free_edge = 0;
  int         m_total = 0;
  int         m_port = 0;
  bit         mvalid = 0;
  bit         m_last = 1;
  bit         m_rs = 0;
  logic [7:0] m_db = 8'h00;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      mvalid    = 0;
      free_edge = 0;
      m_last    = 1;
      m_rs      = 0;
      m_db      = 8'h00;
    end else if (edge_n >= free_edge && (req0 || req1)) begin
      if (req0 && req1) m_port = m_last ? 0 : 1;
      else              m_port = req0 ? 0 : 1;
      m_rs      = (m_port == 1) ? rs1 : rs0;
      m_db      = (m_port == 1) ? data1 : data0;
      m_last    = (m_port == 1);
      m_total   = TS + TPW + TH + ((!m_rs && m_db >= 8'h01 && m_db <= 8'h03) ? TXL : TX);
      t0        = edge_n;
      free_edge = t0 + m_total + 1;
      mvalid    = 1;
    end
  end

  bit chk_on = 0;
  int k;

  // Per-cycle comparison of every output against the model timeline.
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      k = edge_n - t0;
      check("ack0",   ack0,   mvalid && k == 0 && m_port == 0);
      check("ack1",   ack1,   mvalid && k == 0 && m_port == 1);
      check("busy",   busy,   mvalid && k < m_total);
      check("lcd_e",  lcd_e,  mvalid && k >= TS && k < TS + TPW);
      check("lcd_rs", lcd_rs, m_rs);
      check("lcd_db", lcd_db, m_db);
      check("lcd_rw", lcd_rw, 1'b0);
    end
  end

  // Requesters: bit 8 is RS, bits 7:0 the byte; pop on ack, present the next.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         jitter = 0;

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (ack0 && q0.size() > 0) void'(q0.pop_front());
      if (ack1 && q1.size() > 0) void'(q1.pop_front());
    end
    req0  = (q0.size() > 0) && !(jitter && $urandom_range(0, 5) == 0);
    req1  = (q1.size() > 0) && !(jitter && $urandom_range(0, 5) == 0);
    rs0   = (q0.size() > 0) ? q0[0][8] : 1'($urandom);
    data0 = (q0.size() > 0) ? q0[0][7:0] : 8'($urandom);
    rs1   = (q1.size() > 0) ? q1[0][8] : 1'($urandom);
    data1 = (q1.size() > 0) ? q1[0][7:0] : 8'($urandom);
  end

  // Busy pulse length and ack1 edge monitors.
  int blen = 0, last_blen = 0;
  int ack1_edges[$];

  always @(negedge clk) begin
    if (rst) blen = 0;
    else if (busy) blen++;
    else if (blen > 0) begin
      last_blen = blen;
      blen = 0;
    end
    if (!rst && ack1) ack1_edges.push_back(edge_n);
  end

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || edge_n < free_edge) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("drain_within_budget", c < budget, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int c;
    logic [8:0] item;
    repeat (3) @(negedge clk);
    check("rst_lcd_e",  lcd_e,  1'b0);
    check("rst_busy",   busy,   1'b0);
    check("rst_ack0",   ack0,   1'b0);
    check("rst_ack1",   ack1,   1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_db", lcd_db, 8'h00);
    check("rst_lcd_rw", lcd_rw, 1'b0);
    rst = 1'b0;
    chk_on = 1;
    repeat (2) @(negedge clk);

    // Single data write.
    q0.push_back({1'b1, 8'h41});
    wait_drain(500);
    check("single_busy_len", last_blen, TOT);

    // Tie alternation.
    q0.push_back({1'b1, 8'h30}); q0.push_back({1'b1, 8'h30});
    q1.push_back({1'b1, 8'h31}); q1.push_back({1'b1, 8'h31});
    wait_drain(1000);

    // Long versus normal execution wait.
    q0.push_back({1'b0, 8'h01});
    wait_drain(1000);
    check("clear_busy_len", last_blen, TOTL);
    q0.push_back({1'b0, 8'h38});
    wait_drain(1000);
    check("funcset_busy_len", last_blen, TOT);
    q0.push_back({1'b0, 8'h02});
    wait_drain(1000);
    check("home_busy_len", last_blen, TOTL);

    // Port 1 request arriving in the middle of EXEC.
    q0.push_back({1'b0, 8'h0c});
    repeat (TS + TPW + TH + 8) @(negedge clk);
    q1.push_back({1'b0, 8'h80});
    wait_drain(1000);

    // Reset during the E pulse.
    q0.push_back({1'b1, 8'h55});
    c = 0;
    while (!lcd_e && c < 100) begin @(negedge clk); c++; end
    check("reach_pulse", lcd_e, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_lcd_e", lcd_e, 1'b0);
    check("abort_busy",  busy,  1'b0);
    check("abort_ack0",  ack0,  1'b0);
    check("abort_ack1",  ack1,  1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    q0.push_back({1'b1, 8'h60});
    q1.push_back({1'b1, 8'h61});
    c = 0;
    while (!(ack0 || ack1) && c < 50) begin @(negedge clk); c++; end
    check("post_reset_tie_ack0", ack0, 1'b1);
    check("post_reset_tie_ack1", ack1, 1'b0);
    wait_drain(1000);

    // Lone port 1 served back-to-back.
    ack1_edges.delete();
    for (int i = 0; i < 3; i++) q1.push_back({1'b1, 8'h70 + 8'(i)});
    wait_drain(1000);
    check("b2b_ack1_count", ack1_edges.size(), 3);
    for (int i = 1; i < ack1_edges.size(); i++)
      check("b2b_ack1_spacing", ack1_edges[i] - ack1_edges[i-1], TOT + 1);

    // Randomized traffic with request withdrawal.
    jitter = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) item = {1'b0, 8'($urandom_range(0, 4))};
      else                           item = {1'($urandom_range(0, 1)), 8'($urandom)};
      if ($urandom_range(0, 1) == 1) q0.push_back(item);
      else                           q1.push_back(item);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_drain(12000);
    jitter = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
